// File: rtl/cnn_conv1_acc_relu.sv
// Purpose: accumulates one conv1 kernel window of signed products, adds bias, rescales, applies ReLU and saturates.
// Latency: the activation is valid in the cycle after the window's last product is accepted.
// Backpressure: input stalls only while a finished activation is held and out_ready is low.
module cnn_conv1_acc_relu #(
    parameter int PROD_WIDTH = 23,
    parameter int ACC_WIDTH  = 32,
    parameter int BIAS_WIDTH = 14,
    parameter int BIAS_SHIFT = 8,
    parameter int FRAC_SHIFT = 8,
    parameter int OUT_WIDTH  = 14,
    parameter int NTAPS      = 25
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] in_prod,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic [BIAS_WIDTH-1:0] bias,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_tap_count
);

    // Tap counter saturates at a value strictly above NTAPS, so an over-long
    // window can never wrap back around and look like a correct one.
    localparam int CNT_W = $clog2(NTAPS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] NTAPS_C = CNT_W'(NTAPS);

    // Largest positive activation, both as an accumulator-width compare bound
    // and as the output-width saturation value.
    localparam logic [OUT_WIDTH-1:0] OUT_MAX_O = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX_A =
        {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, OUT_MAX_O};

    // Output slot state: ACCUM while the slot is empty/draining, HOLD while a result waits.
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t state;

    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]            cnt;

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] bias_aligned;
    logic signed [ACC_WIDTH-1:0] acc_beat;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] sh;
    logic [OUT_WIDTH-1:0]        act;
    logic [CNT_W-1:0]            cnt_inc;

    logic accept;
    logic close;
    logic pop;

    // Handshake: a held result that downstream refuses blocks new beats.
    assign in_ready = ~(out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign close    = accept & in_last;
    assign pop      = out_valid & out_ready;

    // Window arithmetic: accumulate, add aligned bias, rescale, ReLU and saturate.
    always_comb begin
        prod_ext     = {{(ACC_WIDTH-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
        bias_ext     = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
        bias_aligned = bias_ext <<< BIAS_SHIFT;
        acc_beat     = acc + prod_ext;
        sum          = acc_beat + bias_aligned;
        // Arithmetic shift floors toward -inf, matching the activation scale.
        sh           = sum >>> FRAC_SHIFT;
        act          = '0;
        if (sh < 0) begin
            act = '0;
        end else if (sh > OUT_MAX_A) begin
            act = OUT_MAX_O;
        end else begin
            act = sh[OUT_WIDTH-1:0];
        end
    end

    // Saturating beat count for the window currently being accepted.
    always_comb begin
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end

    // Accumulator, tap counter and sticky tap-count error; a close starts a fresh window.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc           <= '0;
            cnt           <= '0;
            err_tap_count <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                acc <= '0;
                cnt <= '0;
                if (cnt_inc != NTAPS_C) begin
                    err_tap_count <= 1'b1;
                end
            end else begin
                acc <= acc_beat;
                cnt <= cnt_inc;
            end
        end
    end

    // Output slot FSM with registered out_data/out_valid; a close while draining reloads in place.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= ST_ACCUM;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (close) begin
                        out_data  <= act;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (close) begin
                        // Only reachable with out_ready high: old result leaves, new one lands.
                        out_data  <= act;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_conv1_acc_relu.sv
// Purpose: directed bench for cnn_conv1_acc_relu with a queue scoreboard of expected activations.
// Latency: checks out_valid one cycle after each last beat is accepted.
// Backpressure: exercises out_ready low with pending input beats.
module tb_cnn_conv1_acc_relu;

    localparam int PW = 23;
    localparam int BW = 14;
    localparam int OW = 14;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [PW-1:0] in_prod = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [BW-1:0] bias = '0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          err_tap_count;

    int compared = 0;
    int mismatched = 0;
    int exp_q[$];

    cnn_conv1_acc_relu dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .in_prod       (in_prod),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .bias          (bias),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .err_tap_count (err_tap_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input longint obs, input longint expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: floor((sum + bias*256) / 256), ReLU, clamp to 8191.
    function automatic int model(input longint prod_sum, input longint b);
        longint s;
        longint q;
        s = prod_sum + b * 256;
        q = s >>> 8;
        if (q < 0) return 0;
        if (q > 8191) return 8191;
        return int'(q);
    endfunction

    // Scoreboard: every transfer is compared against the oldest expected result.
    always @(negedge ap_clk) begin
        if (!ap_rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check("out_data", longint'(out_data), longint'(exp_q.pop_front()));
            end
        end
    end

    // Drive one beat and wait (bounded) until it is accepted; returns #1 after the accepting edge.
    task automatic beat(input int prod, input bit last);
        bit rdy;
        int waited;
        in_prod  = PW'(prod);
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge ap_clk);
            rdy = in_ready;
            @(posedge ap_clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send n beats of the same product closing the window, push expectation, check latency.
    task automatic send_window(input string tag, input int prod, input int n, input int b);
        bias = BW'(b);
        exp_q.push_back(model(longint'(prod) * n, b));
        for (int i = 0; i < n; i++) begin
            beat(prod, i == n - 1);
        end
        check({tag, "_valid_latency"}, longint'(out_valid), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    initial begin
        int waited;
        // Reset state
        #2;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_err", longint'(err_tap_count), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        idle(2);

        // Back-to-back windows with out_ready high
        send_window("w256", 256, 25, 0);
        check("w256_err", longint'(err_tap_count), 0);
        send_window("wneg", -1000, 25, 0);
        send_window("wsat", 4194303, 25, 0);
        send_window("wbias", 0, 25, 100);
        send_window("wbneg", 0, 25, -5);
        idle(3);
        check("after_full_windows_err", longint'(err_tap_count), 0);

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        send_window("hold1", 256, 25, 0);
        in_prod  = PW'(512);
        in_last  = 1'b0;
        in_valid = 1'b1;
        idle(3);
        check("hold_out_valid", longint'(out_valid), 1);
        check("hold_out_data", longint'(out_data), 25);
        check("hold_in_ready", longint'(in_ready), 0);
        exp_q.push_back(model(512 * 25, 0));
        out_ready = 1'b1;
        beat(512, 1'b0);
        check("drain_out_valid", longint'(out_valid), 0);
        for (int i = 1; i < 25; i++) begin
            beat(512, i == 24);
        end
        check("hold2_valid_latency", longint'(out_valid), 1);
        idle(3);

        // Short window: in_last on third beat
        send_window("short3", 256, 3, 0);
        idle(1);
        check("short3_err", longint'(err_tap_count), 1);
        idle(3);
        check("short3_err_sticky", longint'(err_tap_count), 1);

        // Reset mid-window discards the partial sum and clears the error
        bias = '0;
        for (int i = 0; i < 10; i++) begin
            beat(1000, 1'b0);
        end
        ap_rst = 1'b1;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_err", longint'(err_tap_count), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        idle(1);
        send_window("post_rst", 256, 25, 0);
        idle(1);
        check("post_rst_err", longint'(err_tap_count), 0);

        // Drain the scoreboard (bounded)
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            idle(1);
            waited++;
        end
        check("scoreboard_empty", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cnn_conv1_acc_relu.md
Name: cnn_conv1_acc_relu

Overview:
- Downstream consumer of the conv1 14s x 9s signed product stream (23-bit products).
- Accumulates one kernel window of products into a wide accumulator, then adds the bias.
- Rescales the result by an arithmetic right shift, applies ReLU, and saturates to the 14-bit activation width.
- Emits one activation per window on a valid/ready stream toward the pooling/store stage.

Parameters:
- PROD_WIDTH, 23, signed product width from the multiplier stage
- ACC_WIDTH, 32, signed accumulator width; must be ≥ PROD_WIDTH + clog2(NTAPS) + 1
- BIAS_WIDTH, 14, signed bias width
- BIAS_SHIFT, 8, left shift that aligns the bias to the product fixed-point scale
- FRAC_SHIFT, 8, arithmetic right shift from product scale to activation scale
- OUT_WIDTH, 14, activation width (signed container; value always ≥ 0)
- NTAPS, 25, expected products per window (5x5 kernel)

Ports:
- ap_clk  in  1  clock; all logic on the rising edge
- ap_rst  in  1  asynchronous, active-high reset
- in_prod  in  PROD_WIDTH  signed product
- in_valid  in  1  in_prod is valid
- in_last  in  1  beat is the final product of the window
- in_ready  out  1  block accepts the beat this cycle
- bias  in  BIAS_WIDTH  signed bias; sampled on the in_last beat only
- out_data  out  OUT_WIDTH  activation
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- err_tap_count  out  1  sticky: a window had a beat count ≠ NTAPS

Behaviour:
- Reset (asynchronous, any cycle, including mid-window):
  - acc, tap counter, out_data, out_valid and err_tap_count all go to 0.
  - A partial window is discarded.
  - in_ready is 1 after reset.
- Acceptance:
  - accept = in_valid & in_ready.
  - in_ready = ~(out_valid & ~out_ready). Input stalls only while an unconsumed result is held.
- Accumulation:
  - On accept with in_last = 0: acc ← acc + sext(in_prod) and cnt ← cnt + 1.
  - Addition wraps modulo 2^ACC_WIDTH. With the defaults it cannot overflow.
- Window close (accept with in_last = 1), all in the same cycle:
  - sum = acc + sext(in_prod) + (sext(bias) <<< BIAS_SHIFT), computed in ACC_WIDTH.
  - sh = sum >>> FRAC_SHIFT (arithmetic shift, rounds toward −inf).
  - Result: 0 if sh < 0; 2^(OUT_WIDTH−1)−1 if sh exceeds that value; otherwise sh.
  - The result is registered into out_data and out_valid ← 1.
  - acc ← 0 and cnt ← 0, so the next beat starts a fresh window.
  - If cnt + 1 ≠ NTAPS, err_tap_count ← 1. It is sticky until reset, and the output is still produced.
- Latency: out_valid is high in the cycle after the last beat is accepted.
- Throughput: one beat per cycle. Back-to-back windows run with no bubble while out_ready = 1.
- Output handshake:
  - out_data and out_valid hold while out_valid & ~out_ready.
  - out_valid falls after out_valid & out_ready unless a new window closes in that same cycle.
  - If out_ready is high while a new last beat is accepted, out_valid stays 1 and out_data takes the new result.
- States:
  - ACCUM (cnt counting, out slot empty or draining).
  - HOLD (out_valid & ~out_ready; input stalled).
  - HOLD → ACCUM when out_ready = 1.
  - in_valid = 0 leaves all state unchanged.
- in_last on the first beat of a window gives a one-tap window: the result is computed and the error flag is set when NTAPS ≠ 1.

Test Plan:
- 25 beats of in_prod = 256, bias = 0, out_ready = 1 → out_data = 25 one cycle after the last beat; err_tap_count = 0.
- 25 beats of −1000, bias = 0 → out_data = 0 (ReLU).
- 25 beats of 4194303, bias = 0 → sum 104857575, sh 409599 → out_data = 8191 (saturated).
- 25 beats of 0, bias = 100 → out_data = 100. Then bias = −5 with zeros → out_data = 0.
- Window 1 closes with 25×256 while out_ready = 0 → out_valid holds 25 and in_ready = 0 with beats pending. Raise out_ready → out_valid clears, input resumes, window 2 (25×512) → out_data = 50.
- in_last asserted on the 3rd beat (3×256) → out_data = 3 and err_tap_count = 1 thereafter.
- Assert ap_rst mid-window after 10 beats, then send a clean 25×256 window → out_data = 25 (no residue); err_tap_count = 0.
